ysyx_22041461_id_scoreboard: RTL

Operand-read and hazard-interlock block for the ID stage; the read-side counterpart of the WB register-file/CSR writer. It tracks pending GPR and CSR writes from issue until writeback, reads operands from the register file, and bypasses same-cycle writeback data. It stalls ID on unresolved hazards and hands operands to EXE through a registered valid/ready stage.

---
 rtl/ysyx_22041461_id_scoreboard_if.sv | 46 ++++
 rtl/ysyx_22041461_id_scoreboard.sv | 111 +++++++++++
 2 files changed

// File: rtl/ysyx_22041461_id_scoreboard_if.sv
// ID/WB/EXE signal bundle for the operand-read scoreboard.
// The slave modport is the scoreboard side. The master modport is the pipeline side.
interface ysyx_22041461_id_scoreboard_if;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_en;
    logic        id_rs2_en;
    logic [4:0]  id_rd;
    logic        id_rd_we;
    logic        id_csr_rd;
    logic        id_csr_we;
    logic [4:0]  rf_rs1;
    logic [4:0]  rf_rs2;
    logic [63:0] rf_rs1_data;
    logic [63:0] rf_rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic        wb_csr_we;
    logic [63:0] wb_data;
    logic        wb_commit;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_rs1_data;
    logic [63:0] ex_rs2_data;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd, id_rd_we,
               id_csr_rd, id_csr_we, rf_rs1_data, rf_rs2_data,
               wb_valid, wb_rd, wb_we, wb_csr_we, wb_data, wb_commit, ex_ready,
        output id_ready, rf_rs1, rf_rs2, ex_valid, ex_rs1_data, ex_rs2_data,
               ex_rd, ex_rd_we
    );

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd, id_rd_we,
               id_csr_rd, id_csr_we, rf_rs1_data, rf_rs2_data,
               wb_valid, wb_rd, wb_we, wb_csr_we, wb_data, wb_commit, ex_ready,
        input  id_ready, rf_rs1, rf_rs2, ex_valid, ex_rs1_data, ex_rs2_data,
               ex_rd, ex_rd_we
    );
endinterface

// File: rtl/ysyx_22041461_id_scoreboard.sv
// ID-stage scoreboard. It counts pending GPR/CSR writes, reads operands and bypasses
// committed writeback data. Operands reach EXE through a registered valid/ready stage.
module ysyx_22041461_id_scoreboard #(
    parameter int unsigned CNT_W = 2
) (
    input logic                          clk,
    input logic                          flush,
    ysyx_22041461_id_scoreboard_if.slave io
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic [CNT_W-1:0] r_gpr_cnt [1:31];
    logic [CNT_W-1:0] w_gpr_cnt [0:31];
    logic [CNT_W-1:0] r_csr_cnt;
    logic             r_ex_valid;
    logic [63:0]      r_ex_rs1_data;
    logic [63:0]      r_ex_rs2_data;
    logic [4:0]       r_ex_rd;
    logic             r_ex_rd_we;

    logic             w_rs1_busy, w_rs2_busy, w_rs1_byp, w_rs2_byp;
    logic             w_hazard, w_ready, w_fire;
    logic [63:0]      w_rs1_op, w_rs2_op;
    logic [31:0]      w_inc, w_dec;
    logic             w_csr_inc, w_csr_dec;
    logic             w_wb_fwd;

    // Reset asserts asynchronously but releases only after two clock edges.
    always_ff @(posedge clk or negedge flush) begin
        if (!flush) r_rst_sync <= '0;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Entry 0 reads as zero, so x0 is never busy.
    always_comb begin
        w_gpr_cnt[0] = '0;
        for (int unsigned i = 1; i < 32; i++) w_gpr_cnt[i] = r_gpr_cnt[i];
    end

    assign w_wb_fwd   = io.wb_valid & io.wb_commit & io.wb_we;
    assign w_rs1_busy = io.id_rs1_en & (io.id_rs1 != 5'd0) & (w_gpr_cnt[io.id_rs1] != '0);
    assign w_rs2_busy = io.id_rs2_en & (io.id_rs2 != 5'd0) & (w_gpr_cnt[io.id_rs2] != '0);
    assign w_rs1_byp  = w_wb_fwd & (io.wb_rd == io.id_rs1) & (w_gpr_cnt[io.id_rs1] == CNT_ONE);
    assign w_rs2_byp  = w_wb_fwd & (io.wb_rd == io.id_rs2) & (w_gpr_cnt[io.id_rs2] == CNT_ONE);

    assign w_rs1_op = (io.id_rs1 == 5'd0) ? '0 : (w_rs1_byp ? io.wb_data : io.rf_rs1_data);
    assign w_rs2_op = (io.id_rs2 == 5'd0) ? '0 : (w_rs2_byp ? io.wb_data : io.rf_rs2_data);

    assign w_hazard = (w_rs1_busy & ~w_rs1_byp) | (w_rs2_busy & ~w_rs2_byp)
                    | (io.id_csr_rd & (r_csr_cnt != '0))
                    | (io.id_rd_we & (io.id_rd != 5'd0) & (w_gpr_cnt[io.id_rd] == CNT_MAX))
                    | (io.id_csr_we & (r_csr_cnt == CNT_MAX));
    assign w_ready  = w_rst_n & ~w_hazard & (~r_ex_valid | io.ex_ready);
    assign w_fire   = io.id_valid & w_ready;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int unsigned i = 1; i < 32; i++) begin
            w_inc[i] = w_fire & io.id_rd_we & (io.id_rd == 5'(i));
            w_dec[i] = io.wb_valid & io.wb_we & (io.wb_rd == 5'(i)) & (r_gpr_cnt[i] != '0);
        end
    end
    assign w_csr_inc = w_fire & io.id_csr_we;
    assign w_csr_dec = io.wb_valid & io.wb_csr_we & (r_csr_cnt != '0);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int unsigned i = 1; i < 32; i++) r_gpr_cnt[i] <= '0;
            r_csr_cnt <= '0;
        end else begin
            for (int unsigned i = 1; i < 32; i++) begin
                if (w_inc[i] && !w_dec[i])      r_gpr_cnt[i] <= r_gpr_cnt[i] + CNT_ONE;
                else if (!w_inc[i] && w_dec[i]) r_gpr_cnt[i] <= r_gpr_cnt[i] - CNT_ONE;
            end
            if (w_csr_inc && !w_csr_dec)      r_csr_cnt <= r_csr_cnt + CNT_ONE;
            else if (!w_csr_inc && w_csr_dec) r_csr_cnt <= r_csr_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_rd       <= '0;
            r_ex_rd_we    <= 1'b0;
        end else if (w_fire) begin
            r_ex_valid    <= 1'b1;
            r_ex_rs1_data <= w_rs1_op;
            r_ex_rs2_data <= w_rs2_op;
            r_ex_rd       <= io.id_rd;
            r_ex_rd_we    <= io.id_rd_we;
        end else if (io.ex_ready) begin
            r_ex_valid    <= 1'b0;
        end
    end

    assign io.id_ready    = w_ready;
    assign io.rf_rs1      = io.id_rs1;
    assign io.rf_rs2      = io.id_rs2;
    assign io.ex_valid    = r_ex_valid;
    assign io.ex_rs1_data = r_ex_rs1_data;
    assign io.ex_rs2_data = r_ex_rs2_data;
    assign io.ex_rd       = r_ex_rd;
    assign io.ex_rd_we    = r_ex_rd_we;
endmodule
